priority_decoder: RTL and testbench
===================================

# priority_decoder

Stream-side inverse of the priority encoder. It accepts a framed stream of bit indices over a valid/ready handshake and sets one bit per beat in a DATA_WIDTH-wide bitmap. On the last beat of a frame it presents the bitmap, with duplicate and out-of-range flags, on a registered valid/ready output port. It sits upstream of the priority encoder in request-vector generation and loopback test paths.

## Interface
Parameters:
- DATA_WIDTH, default 8: bitmap width; legal range ≥2. IDX_W = $clog2(DATA_WIDTH).

Ports:
- clk_i  input  1  single clock, rising edge
- rstn_i  input  1  reset, asynchronous, active-low
- idx_i  input  IDX_W  bit index to set
- idx_valid_i  input  1  index beat valid
- idx_last_i  input  1  marks the final beat of a frame
- idx_ready_o  output  1  index beat accepted when high with idx_valid_i
- vec_o  output  DATA_WIDTH  accumulated bitmap
- vec_valid_o  output  1  vec_o, dup_o and oor_o valid
- vec_ready_i  input  1  downstream accepts the output
- dup_o  output  1  at least one index in the frame was already set
- oor_o  output  1  at least one index in the frame was ≥ DATA_WIDTH (only possible when DATA_WIDTH is not a power of 2)

## Operation
- One clock, one reset. The reset is asynchronous and active-low.
- Every output is a flop or a direct decode of state. Reset values:
  - state = ACCUM
  - bitmap, vec_o = 0
  - vec_valid_o = 0, dup_o = 0, oor_o = 0
  - idx_ready_o = 1 (decoded from ACCUM)
- FSM states: ACCUM, HOLD.
- ACCUM:
  - idx_ready_o = 1. A beat is accepted when idx_valid_i & idx_ready_o.
  - On an accepted beat with idx_i < DATA_WIDTH: set bitmap[idx_i]. If that bit was already set, set the dup flag.
  - On an accepted beat with idx_i ≥ DATA_WIDTH: leave the bitmap unchanged and set the oor flag.
  - On an accepted beat with idx_last_i = 1: register the final bitmap (including this beat) into vec_o, and the final flags into dup_o/oor_o. Assert vec_valid_o and go to HOLD.
- HOLD:
  - idx_ready_o = 0. vec_o, dup_o and oor_o stay stable while vec_valid_o & !vec_ready_i.
  - On vec_ready_i: deassert vec_valid_o, clear the working bitmap and flags, and return to ACCUM.
  - vec_o keeps its last value after the handshake; downstream must ignore it while vec_valid_o is low.
- A single-beat frame (last on the first beat) is legal and yields a one-hot vec_o.
- A frame holding every index yields vec_o all ones with no flags.
- idx_i is ignored whenever the handshake does not complete.
- Reset asserted mid-frame or in HOLD: all state returns to reset values immediately (asynchronous). The partial frame is discarded and no vec_valid_o is produced.

## Timing
- Latency: an index beat accepted at edge N with last = 1 gives vec_valid_o = 1 after edge N, so the vector is visible in the cycle following acceptance.
- Inside a frame the input takes one beat per cycle.
- Between frames there is at least one dead cycle: the HOLD cycle in which vec_ready_i is sampled. idx_ready_o rises in the cycle after the output handshake.
- If vec_ready_i is already high when HOLD is entered, the handshake completes on the next edge.
- Maximum sustained rate: a frame of L beats occupies L+1 cycles.
- There is no combinational path from any input to any output. idx_ready_o and vec_valid_o depend on state only.

## Structure
- Package priority_pkg holds:
  - state enum state_t {ACCUM, HOLD}
  - the clog2 helper function, shared with the encoder wrapper
- Sub-module onehot_decode: combinational, parameter DATA_WIDTH, input idx plus enable, output a one-hot vector and an out-of-range bit. The top level ORs its output into the bitmap and detects a duplicate as (bitmap & onehot) != 0.
- A Verilog wrapper matching the existing encoder wrapper style is provided separately for block-design integration. It is not part of this block.

## Test plan
- DATA_WIDTH=8; beats 3, 5, 0 (last on 0); vec_ready_i=1 → vec_o=8'b0010_1001, dup_o=0, oor_o=0, vec_valid_o high for exactly one cycle.
- DATA_WIDTH=8; beats 2, 2 (last) → vec_o=8'b0000_0100, dup_o=1.
- DATA_WIDTH=6; beats 7, 1 (last) → vec_o=6'b00_0010, oor_o=1, dup_o=0.
- Backpressure: single beat idx 4 (last); vec_ready_i low for 5 cycles → vec_o=8'h10 held stable and idx_ready_o=0 throughout. Release → idx_ready_o returns 1 one cycle after the handshake, and the next frame (idx 1, last) gives vec_o=8'h02 with no residue from the previous frame.
- Async reset: beats 6, 7 (not last), then assert rstn_i low between edges → outputs reach reset values before the next edge. After release, beat 0 (last) gives vec_o=8'h01.
- Random frames (1–16 beats, random valid gaps and random vec_ready_i) checked against a scoreboard bitmap model; additionally, feeding vec_o into the priority encoder returns the highest-priority index that was sent.

Source files
------------

// File: rtl/priority_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : priority_pkg
//  Purpose  : Shared types and helpers for the priority encoder/decoder pair.
//  Revision : 1.0  initial release
// ============================================================================
package priority_pkg;

   // Decoder FSM: accumulate a frame, then hold the result until taken.
   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Ceiling log2 for index widths; callers only pass values >= 2.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         w++;
      end
      return w;
   endfunction

endpackage : priority_pkg
`default_nettype wire

// File: rtl/priority_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : priority_decoder_if
//  Purpose  : Index-stream input and bitmap-result output of the decoder.
//  Revision : 1.0  initial release
// ============================================================================
interface priority_decoder_if
   import priority_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = clog2(DATA_WIDTH)
);
   // Index stream (upstream -> decoder)
   logic [IDX_W-1:0]      idx_i;
   logic                  idx_valid_i;
   logic                  idx_last_i;
   logic                  idx_ready_o;

   // Result stream (decoder -> downstream)
   logic [DATA_WIDTH-1:0] vec_o;
   logic                  vec_valid_o;
   logic                  vec_ready_i;
   logic                  dup_o;
   logic                  oor_o;

   // Decoder side
   modport slave (
      input  idx_i, idx_valid_i, idx_last_i, vec_ready_i,
      output idx_ready_o, vec_o, vec_valid_o, dup_o, oor_o
   );

   // Environment side
   modport master (
      output idx_i, idx_valid_i, idx_last_i, vec_ready_i,
      input  idx_ready_o, vec_o, vec_valid_o, dup_o, oor_o
   );
endinterface : priority_decoder_if
`default_nettype wire

// File: rtl/onehot_decode.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_decode
//  Purpose  : Combinational index -> one-hot decode with out-of-range flag.
//  Revision : 1.0  initial release
// ============================================================================
module onehot_decode
   import priority_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  wire logic [clog2(DATA_WIDTH)-1:0] i_idx,
   input  wire logic                         i_en,
   output logic      [DATA_WIDTH-1:0]        o_onehot,
   output logic                              o_oor
);
   localparam int IDX_W = clog2(DATA_WIDTH);

   // One extra bit so DATA_WIDTH itself is representable for the range test.
   localparam logic [IDX_W:0] c_width_ext = (IDX_W+1)'(DATA_WIDTH);

   // Each bitmap position lights when the enabled index selects it.
   for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
      localparam logic [IDX_W-1:0] c_bit_idx = IDX_W'(b);
      assign o_onehot[b] = i_en & (i_idx == c_bit_idx);
   end

   // Only reachable when DATA_WIDTH is not a power of two.
   assign o_oor = i_en & ({1'b0, i_idx} >= c_width_ext);

endmodule : onehot_decode
`default_nettype wire

// File: rtl/priority_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : priority_decoder
//  Purpose  : Accumulates a framed stream of bit indices into a bitmap and
//             presents it with duplicate/out-of-range flags on a registered
//             valid/ready output.
//  Revision : 1.0  initial release
// ============================================================================
module priority_decoder
   import priority_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  wire logic clk_i,
   input  wire logic rstn_i,
   priority_decoder_if.slave bus
);
   localparam int IDX_W = clog2(DATA_WIDTH);

   // FSM state
   state_t r_state;
   state_t w_state_nxt;

   // Working accumulation for the frame in progress
   logic [DATA_WIDTH-1:0] r_bitmap;
   logic                  r_dup;
   logic                  r_oor;

   // Registered result presented downstream
   logic [DATA_WIDTH-1:0] r_vec;
   logic                  r_vec_dup;
   logic                  r_vec_oor;

   // Combinational helpers
   logic                  w_accept;
   logic                  w_done;
   logic [DATA_WIDTH-1:0] w_onehot;
   logic                  w_beat_oor;
   logic [DATA_WIDTH-1:0] w_bitmap_nxt;
   logic                  w_dup_nxt;
   logic                  w_oor_nxt;
   logic                  w_idx_ready;
   logic                  w_vec_valid;

   assign w_accept = bus.idx_valid_i & w_idx_ready;
   assign w_done   = bus.vec_ready_i & w_vec_valid;

   onehot_decode #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_onehot_decode (
      .i_idx    (bus.idx_i),
      .i_en     (w_accept),
      .o_onehot (w_onehot),
      .o_oor    (w_beat_oor)
   );

   // Frame state including the beat being accepted this cycle.
   assign w_bitmap_nxt = r_bitmap | w_onehot;
   assign w_dup_nxt    = r_dup | (|(r_bitmap & w_onehot));
   assign w_oor_nxt    = r_oor | w_beat_oor;

   // State register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: leave ACCUM on the last accepted beat, leave HOLD on take.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM:   if (w_accept && bus.idx_last_i) w_state_nxt = HOLD;
         HOLD:    if (bus.vec_ready_i)            w_state_nxt = ACCUM;
         default:                                 w_state_nxt = ACCUM;
      endcase
   end

   // Outputs decoded from state only, so no input reaches an output directly.
   always_comb begin
      w_idx_ready = 1'b0;
      w_vec_valid = 1'b0;
      case (r_state)
         ACCUM:   w_idx_ready = 1'b1;
         HOLD:    w_vec_valid = 1'b1;
         default: w_idx_ready = 1'b0;
      endcase
   end

   // Accumulate beats, capture the result on the last one, clear after take.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_bitmap  <= '0;
         r_dup     <= 1'b0;
         r_oor     <= 1'b0;
         r_vec     <= '0;
         r_vec_dup <= 1'b0;
         r_vec_oor <= 1'b0;
      end else begin
         if (w_accept) begin
            r_bitmap <= w_bitmap_nxt;
            r_dup    <= w_dup_nxt;
            r_oor    <= w_oor_nxt;
            if (bus.idx_last_i) begin
               r_vec     <= w_bitmap_nxt;
               r_vec_dup <= w_dup_nxt;
               r_vec_oor <= w_oor_nxt;
            end
         end
         // r_vec is left as-is; it is only meaningful while vec_valid_o is high.
         if (w_done) begin
            r_bitmap <= '0;
            r_dup    <= 1'b0;
            r_oor    <= 1'b0;
         end
      end
   end

   assign bus.idx_ready_o = w_idx_ready;
   assign bus.vec_valid_o = w_vec_valid;
   assign bus.vec_o       = r_vec;
   assign bus.dup_o       = r_vec_dup;
   assign bus.oor_o       = r_vec_oor;

   // IDX_W documents the index width seen through the interface.
   logic w_unused_width;
   assign w_unused_width = (IDX_W > 0);

endmodule : priority_decoder
`default_nettype wire

// File: tb/tb_priority_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_priority_decoder
//  Purpose  : Self-checking bench for priority_decoder (widths 8 and 6).
//  Revision : 1.0  initial release
// ============================================================================
module tb_priority_decoder;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   priority_decoder_if #(.DATA_WIDTH(8)) if8 ();
   priority_decoder_if #(.DATA_WIDTH(6)) if6 ();

   priority_decoder #(.DATA_WIDTH(8)) dut8 (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (if8.slave)
   );

   priority_decoder #(.DATA_WIDTH(6)) dut6 (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (if6.slave)
   );

   // Single comparison point for the whole bench.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Highest set bit, i.e. what the priority encoder would return.
   function automatic int msb_of(input logic [7:0] v);
      int m;
      m = -1;
      for (int i = 0; i < 8; i++) if (v[i]) m = i;
      return m;
   endfunction

   // One accepted beat on the width-8 instance; inputs change at edge+1.
   task automatic send8(input logic [2:0] idx, input logic last);
      check("rdy_before_beat", 32'(if8.idx_ready_o), 32'd1);
      if8.idx_i       = idx;
      if8.idx_last_i  = last;
      if8.idx_valid_i = 1'b1;
      @(posedge clk); #1;
      if8.idx_valid_i = 1'b0;
      if8.idx_last_i  = 1'b0;
   endtask

   task automatic send6(input logic [2:0] idx, input logic last);
      if6.idx_i       = idx;
      if6.idx_last_i  = last;
      if6.idx_valid_i = 1'b1;
      @(posedge clk); #1;
      if6.idx_valid_i = 1'b0;
      if6.idx_last_i  = 1'b0;
   endtask

   initial begin
      logic [7:0] m_bitmap;
      logic       m_dup;
      int         m_max;
      int         len;
      int         hc;
      bit         done;
      logic [2:0] ridx;

      if8.idx_i = '0; if8.idx_valid_i = 1'b0; if8.idx_last_i = 1'b0; if8.vec_ready_i = 1'b1;
      if6.idx_i = '0; if6.idx_valid_i = 1'b0; if6.idx_last_i = 1'b0; if6.vec_ready_i = 1'b1;

      // Reset state
      #2 rstn = 1'b0;
      #2;
      check("rst_vec",    32'(if8.vec_o),       32'h0);
      check("rst_vvalid", 32'(if8.vec_valid_o), 32'd0);
      check("rst_dup",    32'(if8.dup_o),       32'd0);
      check("rst_oor",    32'(if8.oor_o),       32'd0);
      check("rst_irdy",   32'(if8.idx_ready_o), 32'd1);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;

      // Frame 3,5,0 with downstream always ready
      send8(3'd3, 1'b0);
      send8(3'd5, 1'b0);
      send8(3'd0, 1'b1);
      check("f1_vvalid", 32'(if8.vec_valid_o), 32'd1);
      check("f1_vec",    32'(if8.vec_o),       32'h29);
      check("f1_dup",    32'(if8.dup_o),       32'd0);
      check("f1_oor",    32'(if8.oor_o),       32'd0);
      check("f1_irdy",   32'(if8.idx_ready_o), 32'd0);
      @(posedge clk); #1;
      check("f1_vvalid_drop", 32'(if8.vec_valid_o), 32'd0);
      check("f1_irdy_back",   32'(if8.idx_ready_o), 32'd1);

      // Duplicate index
      send8(3'd2, 1'b0);
      send8(3'd2, 1'b1);
      check("dup_vec", 32'(if8.vec_o), 32'h04);
      check("dup_flag", 32'(if8.dup_o), 32'd1);
      @(posedge clk); #1;

      // Every index: all ones, no flags
      for (int i = 0; i < 8; i++) send8(3'(i), (i == 7));
      check("all_vec", 32'(if8.vec_o), 32'hFF);
      check("all_dup", 32'(if8.dup_o), 32'd0);
      @(posedge clk); #1;

      // Width 6, out-of-range index
      send6(3'd7, 1'b0);
      send6(3'd1, 1'b1);
      check("w6_vvalid", 32'(if6.vec_valid_o), 32'd1);
      check("w6_vec",    32'(if6.vec_o),       32'h02);
      check("w6_oor",    32'(if6.oor_o),       32'd1);
      check("w6_dup",    32'(if6.dup_o),       32'd0);
      @(posedge clk); #1;

      // Backpressure; index traffic during HOLD must be ignored
      if8.vec_ready_i = 1'b0;
      send8(3'd4, 1'b1);
      if8.idx_i = 3'd1; if8.idx_valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check("bp_vec",    32'(if8.vec_o),       32'h10);
         check("bp_vvalid", 32'(if8.vec_valid_o), 32'd1);
         check("bp_irdy",   32'(if8.idx_ready_o), 32'd0);
         @(posedge clk); #1;
      end
      if8.idx_valid_i = 1'b0;
      if8.vec_ready_i = 1'b1;
      @(posedge clk); #1;
      check("bp_vvalid_drop", 32'(if8.vec_valid_o), 32'd0);
      check("bp_irdy_back",   32'(if8.idx_ready_o), 32'd1);
      send8(3'd1, 1'b1);
      check("bp_next_vec", 32'(if8.vec_o), 32'h02);
      check("bp_next_dup", 32'(if8.dup_o), 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset mid-frame
      send8(3'd6, 1'b0);
      send8(3'd7, 1'b0);
      #2 rstn = 1'b0;
      #1;
      check("ar_vec",    32'(if8.vec_o),       32'h0);
      check("ar_vvalid", 32'(if8.vec_valid_o), 32'd0);
      check("ar_irdy",   32'(if8.idx_ready_o), 32'd1);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      send8(3'd0, 1'b1);
      check("ar_next_vec", 32'(if8.vec_o), 32'h01);
      check("ar_next_dup", 32'(if8.dup_o), 32'd0);
      @(posedge clk); #1;

      // Random frames against a set-of-indices model
      for (int f = 0; f < 60; f++) begin
         len      = $urandom_range(1, 16);
         m_bitmap = '0;
         m_dup    = 1'b0;
         m_max    = -1;
         for (int b = 0; b < len; b++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
               if8.idx_i = 3'($urandom_range(0, 7));
               @(posedge clk); #1;
            end
            ridx = 3'($urandom_range(0, 7));
            if (m_bitmap[ridx]) m_dup = 1'b1;
            m_bitmap[ridx] = 1'b1;
            if (int'(ridx) > m_max) m_max = int'(ridx);
            send8(ridx, (b == len - 1));
         end
         check("rnd_vvalid", 32'(if8.vec_valid_o), 32'd1);
         check("rnd_vec",    32'(if8.vec_o),       32'(m_bitmap));
         check("rnd_dup",    32'(if8.dup_o),       32'(m_dup));
         check("rnd_oor",    32'(if8.oor_o),       32'd0);
         check("rnd_prio",   32'(msb_of(if8.vec_o)), 32'(m_max));
         hc   = 0;
         done = 1'b0;
         while (!done) begin
            if8.vec_ready_i = (hc >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (if8.vec_ready_i) begin
               done = 1'b1;
               check("rnd_vvalid_drop", 32'(if8.vec_valid_o), 32'd0);
               check("rnd_irdy_back",   32'(if8.idx_ready_o), 32'd1);
            end else begin
               check("rnd_hold_vec",    32'(if8.vec_o),       32'(m_bitmap));
               check("rnd_hold_vvalid", 32'(if8.vec_valid_o), 32'd1);
            end
            hc++;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_priority_decoder
`default_nettype wire
